// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO bus controller: controller state encoding,
// default address map and a saturating counter helper.
package mmio_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RAM_ADDR = 3'd1,
        RAM_DATA = 3'd2,
        IO_WAIT  = 3'd3,
        RESP     = 3'd4
    } state_t;

    localparam int DEF_RAM_DEPTH = 32'h0000_2000;
    localparam int DEF_IO_BASE   = 32'h0000_2000;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational address decoder: classifies a CPU address as RAM, I/O channel
// or unmapped, and yields the channel index relative to the I/O base.
module mmio_addr_decode
    import mmio_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int RAM_DEPTH = DEF_RAM_DEPTH,
    parameter int IO_BASE   = DEF_IO_BASE,
    parameter int N_CH      = 16,
    parameter int CH_W      = 4
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit_ram,
    output logic              hit_io,
    output logic [CH_W-1:0]   ch
);

    // One extra bit so IO_BASE+N_CH never wraps at the top of the address space.
    localparam logic [ADDR_W:0] RAM_TOP = (ADDR_W+1)'(RAM_DEPTH);
    localparam logic [ADDR_W:0] IO_LO   = (ADDR_W+1)'(IO_BASE);
    localparam logic [ADDR_W:0] IO_HI   = (ADDR_W+1)'(IO_BASE + N_CH);

    logic [ADDR_W:0] addr_x_s;
    logic [ADDR_W:0] off_s;

    // Range compare and channel offset extraction.
    always_comb begin
        addr_x_s = {1'b0, addr};
        off_s    = addr_x_s - IO_LO;
        hit_ram  = (addr_x_s < RAM_TOP);
        hit_io   = (addr_x_s >= IO_LO) && (addr_x_s < IO_HI);
        ch       = off_s[CH_W-1:0];
    end

endmodule

// File: rtl/mmio_bus_ctrl.sv
// MMIO bus controller: routes single CPU transfers to a synchronous RAM or to
// one of N_CH acknowledge-based I/O channels, with timeout and error counting.
module mmio_bus_ctrl
    import mmio_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int RAM_DEPTH = DEF_RAM_DEPTH,
    parameter int IO_BASE   = DEF_IO_BASE,
    parameter int N_CH      = 16,
    parameter int TIMEOUT   = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [ADDR_W-1:0]      cpu_addr,
    input  logic [DATA_W-1:0]      cpu_wdata,
    output logic [DATA_W-1:0]      cpu_rdata,
    output logic                   cpu_ready,
    output logic                   cpu_err,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic                   ram_we,
    output logic [DATA_W-1:0]      ram_wdata,
    input  logic [DATA_W-1:0]      ram_rdata,
    output logic [N_CH-1:0]        io_sel,
    output logic                   io_we,
    output logic [DATA_W-1:0]      io_wdata,
    input  logic [N_CH*DATA_W-1:0] io_rdata,
    input  logic [N_CH-1:0]        io_ack,
    output logic [7:0]             err_cnt
);

    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [N_CH-1:0] ONE_HOT = N_CH'(1);

    state_t              state_r, state_next_s;
    logic [ADDR_W-1:0]   addr_r;
    logic                we_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [CH_W-1:0]     ch_r;
    logic [CNT_W-1:0]    wait_cnt_r;

    logic                dec_ram_s, dec_io_s;
    logic [CH_W-1:0]     dec_ch_s;
    logic [CH_W-1:0]     ch_next_s;
    logic                we_next_s;
    logic                ack_sel_s;
    logic [DATA_W-1:0]   io_data_sel_s;
    logic                err_next_s;
    logic [DATA_W-1:0]   rdata_next_s;

    mmio_addr_decode #(
        .ADDR_W   (ADDR_W),
        .RAM_DEPTH(RAM_DEPTH),
        .IO_BASE  (IO_BASE),
        .N_CH     (N_CH),
        .CH_W     (CH_W)
    ) u_decode (
        .addr   (cpu_addr),
        .hit_ram(dec_ram_s),
        .hit_io (dec_io_s),
        .ch     (dec_ch_s)
    );

    assign ram_addr      = addr_r;
    assign ram_wdata     = wdata_r;
    assign io_wdata      = wdata_r;
    assign ch_next_s     = (state_r == IDLE) ? dec_ch_s : ch_r;
    assign we_next_s     = (state_r == IDLE) ? cpu_we   : we_r;
    assign ack_sel_s     = io_ack[ch_r];
    assign io_data_sel_s = io_rdata[int'(ch_r)*DATA_W +: DATA_W];

    // Next-state decode plus the response value/flag loaded on entry to RESP.
    always_comb begin
        state_next_s = state_r;
        err_next_s   = 1'b0;
        rdata_next_s = cpu_rdata;
        case (state_r)
            IDLE: begin
                if (!cpu_req) begin
                    state_next_s = IDLE;
                end else if (dec_ram_s) begin
                    state_next_s = RAM_ADDR;
                end else if (dec_io_s) begin
                    state_next_s = IO_WAIT;
                end else begin
                    state_next_s = RESP;
                    err_next_s   = 1'b1;
                    rdata_next_s = '0;
                end
            end
            RAM_ADDR: state_next_s = RAM_DATA;
            RAM_DATA: begin
                state_next_s = RESP;
                rdata_next_s = ram_rdata;
            end
            IO_WAIT: begin
                // An ack on the last permitted cycle takes priority over timeout.
                if (ack_sel_s) begin
                    state_next_s = RESP;
                    rdata_next_s = io_data_sel_s;
                end else if (wait_cnt_r == CNT_W'(TIMEOUT - 1)) begin
                    state_next_s = RESP;
                    err_next_s   = 1'b1;
                    rdata_next_s = '0;
                end else begin
                    state_next_s = IO_WAIT;
                end
            end
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State, request latch and all registered bus/CPU outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            addr_r     <= '0;
            we_r       <= 1'b0;
            wdata_r    <= '0;
            ch_r       <= '0;
            wait_cnt_r <= '0;
            cpu_ready  <= 1'b0;
            cpu_err    <= 1'b0;
            cpu_rdata  <= '0;
            io_sel     <= '0;
            io_we      <= 1'b0;
            ram_we     <= 1'b0;
            err_cnt    <= 8'd0;
        end else begin
            state_r <= state_next_s;
            if (state_r == IDLE && cpu_req) begin
                addr_r  <= cpu_addr;
                we_r    <= cpu_we;
                wdata_r <= cpu_wdata;
                ch_r    <= dec_ch_s;
            end
            wait_cnt_r <= (state_r == IO_WAIT && state_next_s == IO_WAIT) ?
                          wait_cnt_r + CNT_W'(1) : '0;
            cpu_ready  <= (state_next_s == RESP);
            cpu_err    <= err_next_s;
            cpu_rdata  <= rdata_next_s;
            io_sel     <= (state_next_s == IO_WAIT) ? (ONE_HOT << ch_next_s) : '0;
            io_we      <= (state_next_s == IO_WAIT) && we_next_s;
            ram_we     <= (state_next_s == RAM_ADDR) && we_next_s;
            if (state_r == RESP && cpu_err) begin
                err_cnt <= sat_inc8(err_cnt);
            end
        end
    end

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Scoreboard bench for mmio_bus_ctrl: directed transfers push expected
// responses; a monitor pops and compares on every cpu_ready pulse.
module tb_mmio_bus_ctrl;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [15:0]   cpu_addr = 16'h0000;
    logic [15:0]   cpu_wdata = 16'h0000;
    logic [15:0]   cpu_rdata;
    logic          cpu_ready;
    logic          cpu_err;
    logic [15:0]   ram_addr;
    logic          ram_we;
    logic [15:0]   ram_wdata;
    logic [15:0]   ram_rdata = 16'h0000;
    logic [15:0]   io_sel;
    logic          io_we;
    logic [15:0]   io_wdata;
    logic [255:0]  io_rdata;
    logic [15:0]   io_ack;
    logic [7:0]    err_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [15:0] rdata;
        logic        err;
        logic        chk_rd;
    } exp_t;
    exp_t sb_q[$];

    // Environment models
    logic [15:0] mem [0:8191];
    int          io_cyc = 0;
    int          ack_ch = 0;
    int          ack_dly = 0;
    logic        ack_en = 1'b0;
    logic [15:0] noise = 16'h0000;

    mmio_bus_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .io_sel(io_sel), .io_we(io_we), .io_wdata(io_wdata), .io_rdata(io_rdata),
        .io_ack(io_ack), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[12:0]] <= ram_wdata;
        ram_rdata <= mem[ram_addr[12:0]];
    end

    always @(posedge clk) io_cyc <= (io_sel != 16'h0000) ? io_cyc + 1 : 0;

    assign io_ack = ((ack_en && io_sel[ack_ch] && io_cyc == ack_dly) ? (16'h0001 << ack_ch) : 16'h0000)
                    | noise;

    for (genvar k = 0; k < 16; k++) begin : g_iodata
        assign io_rdata[k*16 +: 16] = 16'hBF00 | 16'(k);
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (cpu_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_ready: got ready with empty queue expected none");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_err", {31'd0, cpu_err}, {31'd0, e.err});
                if (e.chk_rd) chk("sb_rdata", {16'd0, cpu_rdata}, {16'd0, e.rdata});
            end
        end
    end

    task automatic xfer(input string nm, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_rd,
                        input logic chk_rd, input logic exp_err, input int exp_lat,
                        input logic [15:0] exp_sel, input int exp_sel_cyc,
                        input int exp_ramwe, input logic rel_rst);
        int cyc = 0, sel_cyc = 0, we_cyc = 0;
        logic sel_ok = 1'b1, addr_ok = 1'b1;
        @(negedge clk);
        if (rel_rst) rst_n = 1'b1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        sb_q.push_back('{exp_rd, exp_err, chk_rd});
        do begin
            @(negedge clk);
            cyc++;
            if (io_sel != 16'h0000) begin
                sel_cyc++;
                if (io_sel !== exp_sel || io_we !== we || io_wdata !== wdata) sel_ok = 1'b0;
            end
            if (ram_we) begin
                we_cyc++;
                if (ram_addr !== addr || ram_wdata !== wdata) addr_ok = 1'b0;
            end
        end while (!cpu_ready && cyc < 60);
        cpu_req = 1'b0;
        chk({nm, "_latency"}, cyc, exp_lat);
        chk({nm, "_sel_cycles"}, sel_cyc, exp_sel_cyc);
        chk({nm, "_sel_value"}, {31'd0, sel_ok}, 32'd1);
        chk({nm, "_ramwe_cycles"}, we_cyc, exp_ramwe);
        chk({nm, "_ram_addr"}, {31'd0, addr_ok}, 32'd1);
    endtask

    initial begin
        int n, cyc, last;
        mem[0] = 16'h1234;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, cpu_ready}, 32'd0);
        chk("rst_err", {31'd0, cpu_err}, 32'd0);
        chk("rst_rdata", {16'd0, cpu_rdata}, 32'd0);
        chk("rst_io_sel", {16'd0, io_sel}, 32'd0);
        chk("rst_we", {30'd0, io_we, ram_we}, 32'd0);
        chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);

        // Reset released on the same cycle the first request is presented.
        xfer("ram_wr", 1'b1, 16'h1FFC, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 3, 16'h0000, 0, 1, 1'b1);
        xfer("ram_rd", 1'b0, 16'h1FFC, 16'h0000, 16'hBEEF, 1'b1, 1'b0, 3, 16'h0000, 0, 0, 1'b0);
        xfer("ram_rd0", 1'b0, 16'h0000, 16'h0000, 16'h1234, 1'b1, 1'b0, 3, 16'h0000, 0, 0, 1'b0);

        ack_en = 1'b1; ack_ch = 15; ack_dly = 3; noise = 16'h4000;
        xfer("io_ch15", 1'b0, 16'h200F, 16'h0000, 16'hBF0F, 1'b1, 1'b0, 5, 16'h8000, 4, 0, 1'b0);
        noise = 16'h0000; ack_ch = 0; ack_dly = 0;
        xfer("io_wr0", 1'b1, 16'h2000, 16'h5A5A, 16'hBF00, 1'b1, 1'b0, 2, 16'h0001, 1, 0, 1'b0);
        ack_ch = 5; ack_dly = 14;
        xfer("io_last", 1'b0, 16'h2005, 16'h0000, 16'hBF05, 1'b1, 1'b0, 16, 16'h0020, 15, 0, 1'b0);
        chk("err_cnt_0", {24'd0, err_cnt}, 32'd0);

        ack_en = 1'b0; ack_ch = 3;
        xfer("io_tmo", 1'b0, 16'h2003, 16'h0000, 16'h0000, 1'b1, 1'b1, 16, 16'h0008, 15, 0, 1'b0);
        @(negedge clk);
        chk("err_cnt_1", {24'd0, err_cnt}, 32'd1);

        xfer("unmap_4000", 1'b1, 16'h4000, 16'h1111, 16'h0000, 1'b1, 1'b1, 1, 16'h0000, 0, 0, 1'b0);
        xfer("unmap_2010", 1'b0, 16'h2010, 16'h0000, 16'h0000, 1'b1, 1'b1, 1, 16'h0000, 0, 0, 1'b0);
        @(negedge clk);
        chk("err_cnt_3", {24'd0, err_cnt}, 32'd3);

        // Abort an I/O wait with reset; no response may appear.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2001;
        repeat (3) @(negedge clk);
        chk("abort_sel_before", {16'd0, io_sel}, 32'h0002);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_sel_async", {16'd0, io_sel}, 32'd0);
        chk("abort_err_cnt", {24'd0, err_cnt}, 32'd0);
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        xfer("post_rst_rd", 1'b0, 16'h0000, 16'h0000, 16'h1234, 1'b1, 1'b0, 3, 16'h0000, 0, 0, 1'b1);

        // Held request: back-to-back unmapped transfers until err_cnt saturates.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4000;
        for (int i = 0; i < 300; i++) sb_q.push_back('{16'h0000, 1'b1, 1'b1});
        n = 0; cyc = 0; last = 0;
        while (n < 300 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (cpu_ready) begin
                n++;
                if (n > 1 && n <= 4) chk("held_gap", cyc - last, 2);
                last = cyc;
                if (n == 300) cpu_req = 1'b0;
            end
        end
        cpu_req = 1'b0;
        chk("held_count", n, 300);
        repeat (3) @(negedge clk);
        chk("err_cnt_sat", {24'd0, err_cnt}, 32'd255);
        chk("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmio_bus_ctrl.md
MMIO_BUS_CTRL -- requirements
Module: mmio_bus_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data word width.
REQ-002 SHALL have parameter ADDR_W, default 16, address width.
REQ-003 SHALL have parameter RAM_DEPTH, default 16'h2000; RAM occupies addresses 0..RAM_DEPTH-1.
REQ-004 SHALL have parameter IO_BASE, default 16'h2000; I/O channels occupy IO_BASE..IO_BASE+N_CH-1; IO_BASE >= RAM_DEPTH.
REQ-005 SHALL have parameter N_CH, default 16, I/O channel count, 1..64.
REQ-006 SHALL have parameter TIMEOUT, default 15, maximum I/O wait cycles, >= 1.
REQ-007 SHALL have a single clock and an asynchronous active-low reset; ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-008 Ports: cpu_req  in  1  transfer request, held until cpu_ready; cpu_we  in  1  write when 1; cpu_addr  in  ADDR_W; cpu_wdata  in  DATA_W.
REQ-009 Ports: cpu_rdata  out  DATA_W  read data; cpu_ready  out  1  one-cycle completion pulse; cpu_err  out  1  error flag, valid with cpu_ready.
REQ-010 Ports: ram_addr  out  ADDR_W; ram_we  out  1; ram_wdata  out  DATA_W; ram_rdata  in  DATA_W, synchronous RAM, valid one cycle after ram_addr.
REQ-011 Ports: io_sel  out  N_CH  one-hot select; io_we  out  1; io_wdata  out  DATA_W; io_rdata  in  N_CH*DATA_W, channel k in bits [k*DATA_W +: DATA_W]; io_ack  in  N_CH  per-channel acknowledge.
REQ-012 Ports: err_cnt  out  8  saturating count of errored transfers.

Function
REQ-013 SHALL implement FSM states IDLE, RAM_ADDR, RAM_DATA, IO_WAIT, RESP.
REQ-014 IDLE: on cpu_req=1, latch cpu_addr/cpu_we/cpu_wdata; decode: addr < RAM_DEPTH -> RAM_ADDR; IO_BASE <= addr < IO_BASE+N_CH -> IO_WAIT; otherwise -> RESP with error.
REQ-015 RAM_ADDR: drive ram_addr/ram_wdata from latched values; ram_we = latched we for this single cycle; -> RAM_DATA.
REQ-016 RAM_DATA: capture ram_rdata into read register (writes: capture, value don't-care); -> RESP.
REQ-017 IO_WAIT: io_sel bit (addr-IO_BASE) high, all others low; io_we = latched we, io_wdata = latched wdata, all held stable for the whole state.
REQ-018 IO_WAIT: wait counter cleared on entry, increments each cycle io_ack[ch]=0; io_ack of non-selected channels ignored.
REQ-019 IO_WAIT: io_ack[ch]=1 -> capture channel io_rdata, -> RESP, no error; ack on the final allowed cycle wins over timeout.
REQ-020 IO_WAIT: after TIMEOUT cycles without ack -> RESP with error, read register = 0; io_sel high for exactly TIMEOUT cycles.
REQ-021 RESP: cpu_ready=1 for exactly one cycle, cpu_rdata = read register, cpu_err = error flag; -> IDLE.
REQ-022 Unmapped address: no ram_we, io_sel or io_we asserted; cpu_rdata = 0, cpu_err = 1.
REQ-023 Latency from accepting edge to cpu_ready: RAM 3 cycles; I/O (ack after n wait cycles) n+2; unmapped 1.
REQ-024 cpu_req sampled only in IDLE; held request after RESP starts a new transfer on the next cycle.
REQ-025 err_cnt increments by 1 in each RESP cycle with error; saturates at 255.
REQ-026 cpu_ready, cpu_err, cpu_rdata, io_sel SHALL be register outputs; ram_we/io_we high only in their states.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state IDLE, cpu_ready=0, cpu_err=0, cpu_rdata=0, io_sel=0, io_we=0, ram_we=0, wait counter=0, err_cnt=0.
REQ-028 Reset mid-transfer SHALL abort it with no cpu_ready pulse; first transfer accepted on the first rising edge with rst_n=1.

Structure
REQ-029 Shared package mmio_pkg SHALL hold the state enum and default address-map constants (RAM_DEPTH, IO_BASE).
REQ-030 Address decode SHALL be a sub-module mmio_addr_decode (combinational: hit_ram, hit_io, ch index).

Verification
REQ-031 Write 16'hBEEF to 16'h1FFC -> ram_we=1 one cycle with ram_addr=16'h1FFC; cpu_ready 3 cycles after accept, cpu_err=0.
REQ-032 Read 16'h200F, channel 15 acks after 3 wait cycles with 16'hBF0F -> io_sel=16'h8000 for 4 cycles; cpu_rdata=16'hBF0F, cpu_err=0.
REQ-033 Read 16'h2003, channel 3 never acks -> io_sel[3] high exactly 15 cycles; cpu_ready with cpu_err=1, cpu_rdata=0; err_cnt=1.
REQ-034 Write 16'h4000 -> no ram_we/io_sel; cpu_ready 1 cycle after accept, cpu_err=1.
REQ-035 rst_n low during IO_WAIT on 16'h2001 -> io_sel=0 immediately, no cpu_ready; subsequent RAM read of 16'h0000 completes normally.
REQ-036 cpu_req held for 300 unmapped transfers -> err_cnt saturates at 255.
